// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Initiator for the small 2-bit-operand ALU. It accepts an op command over a
//   valid/ready port and drives a/b/funct to the external combinational ALU.
//   It holds those inputs for a settle window, then samples the ALU result.
//   The result goes back over a valid/ready response port. One command can be
//   replayed 1..4 times back to back, with one response per issue.
//
//   Optional feature: define SEQ_CHECK_EN to add a reference model of the ALU.
//   The model is checked at every sample, and any mismatch sets check_err,
//   which stays high until reset. With the macro undefined, check_err is tied
//   low and the port list is unchanged.
//
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//     cmd_a, cmd_b, cmd_funct         command operands and function select
//     cmd_repeat                      issue count minus one
//     alu_a, alu_b, alu_funct         registered drive to the ALU
//     alu_out                         ALU result
//     rsp_valid/rsp_ready             response handshake
//     rsp_data, rsp_last              sampled result, final-issue flag
//     issued_cnt                      wrapping count of completed responses
//     check_err                       sticky reference-check error
module alu_op_sequencer #(
  parameter int OP_W          = 2,
  parameter int OUT_W         = 5,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_a,
  input  logic [OP_W-1:0]  cmd_b,
  input  logic [OP_W-1:0]  cmd_funct,
  input  logic [1:0]       cmd_repeat,
  output logic [OP_W-1:0]  alu_a,
  output logic [OP_W-1:0]  alu_b,
  output logic [OP_W-1:0]  alu_funct,
  input  logic [OUT_W-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic             rsp_last,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             check_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] rem;
  logic [3:0] settle;
  logic       rsp_fire;

  assign cmd_ready = (state == IDLE);
  assign rsp_fire  = rsp_valid & rsp_ready;

`ifdef SEQ_CHECK_EN
  localparam logic [OP_W-1:0] F_ADD = OP_W'(0);
  localparam logic [OP_W-1:0] F_SUB = OP_W'(1);
  localparam logic [OP_W-1:0] F_AND = OP_W'(2);

  logic [OUT_W-1:0] ext_a;
  logic [OUT_W-1:0] ext_b;
  logic [OUT_W-1:0] expected;
  logic             mismatch;

  // Operands are zero-extended, and every result wraps modulo 2^OUT_W.
  always_comb begin
    ext_a    = OUT_W'(alu_a);
    ext_b    = OUT_W'(alu_b);
    expected = '0;
    if (alu_funct == F_ADD)      expected = ext_a + ext_b;
    else if (alu_funct == F_SUB) expected = ext_a - ext_b;
    else if (alu_funct == F_AND) expected = ext_a & ext_b;
    else                         expected = ext_a * ext_b;
  end

  assign mismatch = (expected != alu_out);
`else
  assign check_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rem        <= '0;
      settle     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_funct  <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_last   <= 1'b0;
      issued_cnt <= '0;
`ifdef SEQ_CHECK_EN
      check_err  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // The ALU inputs keep their last driven values while idle.
          if (cmd_valid) begin
            alu_a     <= cmd_a;
            alu_b     <= cmd_b;
            alu_funct <= cmd_funct;
            rem       <= cmd_repeat;
            settle    <= SETTLE_INIT;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle == 4'd0) begin
            rsp_data  <= alu_out;
            rsp_valid <= 1'b1;
            rsp_last  <= (rem == 2'd0);
            state     <= RESP;
`ifdef SEQ_CHECK_EN
            if (mismatch) check_err <= 1'b1;
`endif
          end else begin
            settle <= settle - 4'd1;
          end
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_valid  <= 1'b0;
            issued_cnt <= issued_cnt + CNT_W'(1);
            if (rem == 2'd0) begin
              state <= IDLE;
            end else begin
              rem    <= rem - 2'd1;
              settle <= SETTLE_INIT;
              state  <= DRIVE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
